// File: rtl/chan_mux_scan.sv
// Channel multiplexer with manual select and timed auto-scan.
// All outputs are registered; dout always carries the channel named by cur_sel.
module chan_mux_scan #(
  parameter int WIDTH    = 4,
  parameter int CHANNELS = 4,
  parameter int DWELL    = 8,
  localparam int SELW    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      mode,
  input  logic [SELW-1:0]           sel,
  input  logic                      hold,
  input  logic [CHANNELS*WIDTH-1:0] din,
  output logic [WIDTH-1:0]          dout,
  output logic [SELW-1:0]           cur_sel,
  output logic                      strobe,
  output logic                      sel_err
);

  localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0]   LAST_CNT = CW'(DWELL - 1);
  localparam logic [SELW-1:0] LAST_CH  = SELW'(CHANNELS - 1);

  logic [WIDTH-1:0] chan [CHANNELS];

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
    assign chan[gi] = din[gi*WIDTH +: WIDTH];
  end

  logic [CW-1:0]    count_q, count_d;
  logic [SELW-1:0]  cur_sel_q, cur_sel_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             strobe_q, strobe_d;
  logic             sel_err_q, sel_err_d;

  logic             sel_ok;
  logic             at_last;
  logic [SELW-1:0]  scan_sel;
  logic [SELW-1:0]  mux_idx;
  logic [WIDTH-1:0] mux_out;

  assign sel_ok  = ({1'b0, sel} < (SELW+1)'(CHANNELS));
  assign at_last = (count_q == LAST_CNT);

  // Explicit wrap keeps non-power-of-two channel counts in range.
  always_comb begin
    scan_sel = cur_sel_q;
    if (!hold && at_last) begin
      scan_sel = (cur_sel_q == LAST_CH) ? '0 : cur_sel_q + 1'b1;
    end
  end

  assign mux_idx = mode ? scan_sel : sel;

  always_comb begin
    mux_out = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (mux_idx == SELW'(k)) begin
        mux_out = chan[k];
      end
    end
  end

  always_comb begin
    count_d   = count_q;
    cur_sel_d = cur_sel_q;
    dout_d    = mux_out;
    strobe_d  = 1'b0;
    sel_err_d = 1'b0;
    if (!mode) begin
      count_d = '0;
      if (sel_ok) begin
        cur_sel_d = sel;
      end else begin
        dout_d    = '0;
        sel_err_d = 1'b1;
      end
    end else if (!hold) begin
      if (at_last) begin
        count_d   = '0;
        cur_sel_d = scan_sel;
        strobe_d  = 1'b1;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q   <= '0;
      cur_sel_q <= '0;
      dout_q    <= '0;
      strobe_q  <= 1'b0;
      sel_err_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      cur_sel_q <= cur_sel_d;
      dout_q    <= dout_d;
      strobe_q  <= strobe_d;
      sel_err_q <= sel_err_d;
    end
  end

  assign dout    = dout_q;
  assign cur_sel = cur_sel_q;
  assign strobe  = strobe_q;
  assign sel_err = sel_err_q;

endmodule

// File: tb/tb_chan_mux_scan.sv
// Directed bench for chan_mux_scan: a scan-position model checked every cycle
// plus literal expectations for the manual, scan, hold, reset and mode-switch cases.
module tb_chan_mux_scan;
  localparam int W  = 4;
  localparam int CH = 3;
  localparam int DW = 3;
  localparam int SW = 2;

  logic            clk   = 1'b0;
  logic            rst_n = 1'b1;
  logic            mode  = 1'b0;
  logic            hold  = 1'b0;
  logic [SW-1:0]   sel   = '0;
  logic [CH*W-1:0] din   = 12'hCBA;
  logic [W-1:0]    dout;
  logic [SW-1:0]   cur_sel;
  logic            strobe;
  logic            sel_err;

  chan_mux_scan #(.WIDTH(W), .CHANNELS(CH), .DWELL(DW)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .hold(hold), .din(din),
    .dout(dout), .cur_sel(cur_sel), .strobe(strobe), .sel_err(sel_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  // Model: a single scan position = channel*DWELL + dwell count, modulo CH*DW.
  int           phase    = 0;
  logic [W-1:0] m_dout   = '0;
  logic         m_strobe = 1'b0;
  logic         m_err    = 1'b0;

  function automatic logic [W-1:0] chunk(input int k);
    return din[k*W +: W];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int np;
    if (!rst_n) begin
      phase <= 0; m_dout <= '0; m_strobe <= 1'b0; m_err <= 1'b0;
    end else if (!mode) begin
      m_strobe <= 1'b0;
      if (int'(sel) < CH) begin
        phase <= int'(sel) * DW; m_err <= 1'b0; m_dout <= chunk(int'(sel));
      end else begin
        phase <= (phase / DW) * DW; m_err <= 1'b1; m_dout <= '0;
      end
    end else if (hold) begin
      m_strobe <= 1'b0; m_err <= 1'b0; m_dout <= chunk(phase / DW);
    end else begin
      np = (phase + 1) % (CH * DW);
      phase <= np; m_strobe <= (np % DW == 0); m_err <= 1'b0; m_dout <= chunk(np / DW);
    end
  end

  always @(negedge clk) begin
    chk("model_dout", int'(dout), int'(m_dout));
    chk("model_cur_sel", int'(cur_sel), phase / DW);
    chk("model_strobe", int'(strobe), int'(m_strobe));
    chk("model_sel_err", int'(sel_err), int'(m_err));
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string nm, input int d, input int c, input int s, input int e);
    chk({nm, "_dout"}, int'(dout), d);
    chk({nm, "_cur_sel"}, int'(cur_sel), c);
    chk({nm, "_strobe"}, int'(strobe), s);
    chk({nm, "_sel_err"}, int'(sel_err), e);
  endtask

  int exp_cs [9] = '{0, 0, 1, 1, 1, 2, 2, 2, 0};
  int exp_st [9] = '{0, 0, 1, 0, 0, 1, 0, 0, 1};
  int exp_do [9] = '{'hA, 'hA, 'hB, 'hB, 'hB, 'hC, 'hC, 'hC, 'hA};

  initial begin
    #1 rst_n = 1'b0;
    #1 lit("reset", 0, 0, 0, 0);
    @(posedge clk); @(posedge clk); #2 rst_n = 1'b1;

    // Manual sweep and bad select
    sel = 2'd0; tick(); lit("man0", 'hA, 0, 0, 0);
    sel = 2'd1; tick(); lit("man1", 'hB, 1, 0, 0);
    sel = 2'd2; tick(); lit("man2", 'hC, 2, 0, 0);
    sel = 2'd3; tick(); lit("badsel", 0, 2, 0, 1);
    sel = 2'd1; tick(); lit("recover", 'hB, 1, 0, 0);

    // Scan from reset with wrap
    rst_n = 1'b0; #1 rst_n = 1'b1; mode = 1'b1;
    for (int i = 0; i < 9; i++) begin
      tick(); lit($sformatf("scan%0d", i), exp_do[i], exp_cs[i], exp_st[i], 0);
    end

    // Hold on channel 1 at count 1
    for (int i = 0; i < 4; i++) tick();
    chk("pre_hold_cur_sel", int'(cur_sel), 1);
    hold = 1'b1; tick(); lit("hold0", 'hB, 1, 0, 0);
    din = 12'hC5A;
    for (int i = 1; i < 5; i++) begin
      tick(); lit($sformatf("hold%0d", i), 'h5, 1, 0, 0);
    end
    hold = 1'b0;
    tick(); lit("rel1", 'h5, 1, 0, 0);
    tick(); lit("rel2", 'hC, 2, 1, 0);

    // Async reset during a strobe cycle
    #1 rst_n = 1'b0;
    #1 lit("async_rst", 0, 0, 0, 0);
    rst_n = 1'b1;
    tick(); lit("rs1", 'hA, 0, 0, 0);
    tick(); lit("rs2", 'hA, 0, 0, 0);
    tick(); lit("rs3", 'h5, 1, 1, 0);

    // Mode switch mid-dwell on channel 2
    for (int i = 0; i < 4; i++) tick();
    chk("pre_switch_cur_sel", int'(cur_sel), 2);
    mode = 1'b0; sel = 2'd0; tick(); lit("sw_man", 'hA, 0, 0, 0);
    mode = 1'b1;
    tick(); lit("sw1", 'hA, 0, 0, 0);
    tick(); lit("sw2", 'hA, 0, 0, 0);
    tick(); lit("sw3", 'h5, 1, 1, 0);

    // Mode beats hold; scan resumes from a retained index after an error
    hold = 1'b1; mode = 1'b0; sel = 2'd2; tick(); lit("mode_prio", 'hC, 2, 0, 0);
    hold = 1'b0; sel = 2'd3; tick(); lit("err2", 0, 2, 0, 1);
    mode = 1'b1;
    tick(); lit("err_scan1", 'hC, 2, 0, 0);
    tick(); lit("err_scan2", 'hC, 2, 0, 0);
    tick(); lit("err_scan3", 'hA, 0, 1, 0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/chan_mux_scan.md
CHAN_MUX_SCAN -- requirements
Module: chan_mux_scan

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the bits per channel; legal values are 1..32.
REQ-002 The block SHALL have parameter CHANNELS, default 4, giving the number of input channels; legal values are 2..16.
REQ-003 The block SHALL have parameter DWELL, default 8, giving the clock cycles per channel in scan mode; legal values are 1..65535.
REQ-004 SELW SHALL denote the select width, computed as $clog2(CHANNELS).
REQ-005 The block SHALL have one clock; reset is asynchronous and active-low. Ports are clk and rst_n.
REQ-006 clk  input  1  Rising-edge clock for all state.
REQ-007 rst_n  input  1  Asynchronous, active-low reset.
REQ-008 mode  input  1  Mode select: 0 = manual select, 1 = auto-scan.
REQ-009 sel  input  SELW  Manual channel index; used only when mode=0.
REQ-010 hold  input  1  In scan mode, freezes the dwell counter and the channel pointer.
REQ-011 din  input  CHANNELS*WIDTH  Flattened channel data; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-012 dout  output  WIDTH  Registered data of the current channel.
REQ-013 cur_sel  output  SELW  Registered index of the channel currently driving dout.
REQ-014 strobe  output  1  One-cycle pulse in the cycle the scan pointer advances.
REQ-015 sel_err  output  1  Registered flag; high when manual sel >= CHANNELS.

Function
REQ-016 Every output SHALL be registered: dout reflects din[cur_sel] sampled at the same edge that updates cur_sel, giving one cycle of latency from din/sel to dout.
REQ-017 Manual mode (mode=0): each edge SHALL set cur_sel <= sel and dout <= din[sel], and SHALL clear the dwell counter and strobe.
REQ-018 Manual mode, sel >= CHANNELS: the block SHALL set dout <= 0, hold cur_sel at its previous value, and set sel_err <= 1; otherwise sel_err <= 0.
REQ-019 Scan mode (mode=1, hold=0): the dwell counter SHALL count 0..DWELL-1.
REQ-020 Scan mode, counter at DWELL-1: the counter SHALL reset to 0, cur_sel SHALL advance by 1, and strobe SHALL be 1 for exactly that cycle.
REQ-021 Scan mode wrap-around: cur_sel SHALL go from CHANNELS-1 to 0, including non-power-of-two CHANNELS; no out-of-range index is ever reached.
REQ-022 DWELL=1: cur_sel SHALL advance every cycle, and strobe SHALL stay high continuously while scanning.
REQ-023 Scan mode: dout SHALL track din[cur_sel] every cycle, including while dwelling, and SHALL show the new channel's data in the same cycle cur_sel changes.
REQ-024 Scan mode: sel_err SHALL be 0 and sel SHALL be ignored.
REQ-025 hold=1 in scan mode: the counter and cur_sel SHALL freeze, strobe SHALL be 0, and dout SHALL continue tracking din[cur_sel].
REQ-026 After hold is released, counting SHALL resume from the frozen count.
REQ-027 Transition mode 0->1: scanning SHALL start from the current cur_sel with the counter at 0.
REQ-028 Transition mode 0->1 from an error state (sel_err=1): scanning SHALL start from the retained cur_sel.
REQ-029 Transition mode 1->0: the next edge SHALL apply REQ-017/REQ-018 immediately, with no completion of the dwell.
REQ-030 hold and mode change in the same cycle: mode SHALL take priority.

Reset
REQ-031 While rst_n=0, independent of clk: dout=0, cur_sel=0, strobe=0, sel_err=0, and the dwell counter=0.
REQ-032 Reset asserted mid-dwell or mid-strobe SHALL clear all state immediately.
REQ-033 After rst_n deasserts, the first active edge SHALL behave per the current mode, with scan starting at channel 0 and count 0.

Verification (bench uses WIDTH=4, CHANNELS=3, DWELL=3, din = {4'hC,4'hB,4'hA})
REQ-034 Manual sweep: mode=0, sel = 0,1,2 on successive edges -> dout = A,B,C one cycle later; cur_sel follows; sel_err=0.
REQ-035 Bad select: mode=0, sel=3 -> next edge dout=0, sel_err=1, cur_sel keeps its prior value (2); then sel=1 -> dout=B, sel_err=0.
REQ-036 Scan with wrap: mode=1 from reset -> cur_sel 0,0,0,1,1,1,2,2,2,0...; strobe high on the cycles where cur_sel changes (every 3rd cycle); dout = A..B..C..A.
REQ-037 Hold: during scan, hold=1 for 5 cycles at count 1 on channel 1 -> cur_sel stays 1, no strobe, dout tracks a din change on channel 1 to 4'h5; after release, advance occurs 2 cycles later.
REQ-038 Async reset: rst_n pulsed low between clock edges during a strobe cycle -> all outputs 0 immediately; after release, scan restarts at channel 0 with a full 3-cycle dwell.
REQ-039 Mode switch: scanning on channel 2 at count 1, mode -> 0 with sel=0 -> next edge dout=A, cur_sel=0, no strobe; mode -> 1 again -> dwell restarts at channel 0.
